// File: rtl/uart_coord_xmtr.sv
// Serialises two 32-bit face coordinates as eight 8N1 UART frames, LSB first,
// gating each frame on the laptop's clear-to-send line.
module uart_coord_xmtr #(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned BAUD         = 115_200,
  parameter int unsigned CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0][31:0] face_coords,
  input  logic             face_coords_ready,
  input  logic             uart_cts,
  output logic             uart_tx,
  output logic             tx_busy,
  output logic             tx_done
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitCts,
    StStart,
    StData,
    StStop,
    StDone
  } state_e;

  state_e          state;
  logic            ready_q;
  logic            start;
  logic [63:0]     shift_buf;
  logic [7:0]      cur_byte;
  logic [CntW-1:0] baud_cnt;
  logic            bit_end;
  logic [2:0]      bit_idx;
  logic [2:0]      bit_nxt;
  logic [2:0]      byte_idx;

  assign start    = face_coords_ready & ~ready_q;
  assign cur_byte = shift_buf[7:0];
  assign bit_end  = (baud_cnt == CntLast);
  assign bit_nxt  = bit_idx + 3'd1;

  // Outputs are registered alongside the state so uart_tx changes on the
  // same edge as the state it belongs to.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      ready_q   <= 1'b0;
      shift_buf <= '0;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      uart_tx   <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      ready_q <= face_coords_ready;
      tx_done <= 1'b0;
      unique case (state)
        StIdle: begin
          uart_tx <= 1'b1;
          if (start) begin
            shift_buf <= face_coords;
            byte_idx  <= '0;
            baud_cnt  <= '0;
            tx_busy   <= 1'b1;
            state     <= StWaitCts;
          end
        end
        StWaitCts: begin
          uart_tx <= 1'b1;
          if (uart_cts) begin
            uart_tx  <= 1'b0;
            baud_cnt <= '0;
            state    <= StStart;
          end
        end
        StStart: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            uart_tx  <= cur_byte[0];
            state    <= StData;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        StData: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= StStop;
            end else begin
              bit_idx <= bit_nxt;
              uart_tx <= cur_byte[bit_nxt];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        StStop: begin
          uart_tx <= 1'b1;
          if (bit_end) begin
            baud_cnt <= '0;
            if (byte_idx == 3'd7) begin
              tx_done <= 1'b1;
              tx_busy <= 1'b0;
              state   <= StDone;
            end else begin
              byte_idx  <= byte_idx + 3'd1;
              shift_buf <= {8'h00, shift_buf[63:8]};
              state     <= StWaitCts;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        StDone: begin
          uart_tx  <= 1'b1;
          baud_cnt <= '0;
          state    <= StIdle;
        end
        default: begin
          uart_tx <= 1'b1;
          tx_busy <= 1'b0;
          state   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_coord_xmtr.sv
// Directed bench for uart_coord_xmtr at 4 clocks per bit: logs the line per cycle
// after a ready edge, decodes frames and compares against hand-computed bytes.
module tb_uart_coord_xmtr;

  localparam int CPB  = 4;
  localparam int MAXN = 1024;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [1:0][31:0] face_coords = '0;
  logic             face_coords_ready = 1'b0;
  logic             uart_cts = 1'b1;
  logic             uart_tx;
  logic             tx_busy;
  logic             tx_done;

  uart_coord_xmtr #(.CLKS_PER_BIT(CPB)) dut (
    .clock            (clock),
    .reset            (reset),
    .face_coords      (face_coords),
    .face_coords_ready(face_coords_ready),
    .uart_cts         (uart_cts),
    .uart_tx          (uart_tx),
    .tx_busy          (tx_busy),
    .tx_done          (tx_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    logic [63:0] exp;  // expected bytes in line order, first byte in [63:56]
  } vec_t;

  vec_t vecs[3];

  int errors = 0;
  int checks = 0;

  logic tx_log[MAXN];
  logic busy_log[MAXN];
  logic done_log[MAXN];

  // Mid-capture events, indexed by observed cycle; -1 disables.
  int          cts_off_at, cts_on_at, pulse_at, rst_at, coords_at;
  logic [63:0] coords_new;

  logic [7:0] dec_byte[16];
  int         dec_pos[16];
  int         n_dec, stop_bad, done_cnt, done_pos;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_ctl();
    cts_off_at = -1;
    cts_on_at  = -1;
    pulse_at   = -1;
    rst_at     = -1;
    coords_at  = -1;
    coords_new = '0;
  endtask

  // The negedge where ready rises lies in the start cycle T; log index m is cycle T+m.
  task automatic launch(input logic [63:0] coords);
    face_coords_ready = 1'b0;
    @(negedge clock);
    face_coords = coords;
    tx_log[0]   = uart_tx;
    face_coords_ready = 1'b1;
  endtask

  task automatic capture(input int n);
    for (int m = 1; m <= n; m++) begin
      @(negedge clock);
      tx_log[m]   = uart_tx;
      busy_log[m] = tx_busy;
      done_log[m] = tx_done;
      if (m == cts_off_at) uart_cts = 1'b0;
      if (m == cts_on_at) uart_cts = 1'b1;
      if (pulse_at > 0 && m == pulse_at) face_coords_ready = 1'b0;
      if (pulse_at > 0 && m == pulse_at + 1) face_coords_ready = 1'b1;
      if (m == coords_at) face_coords = coords_new;
      if (rst_at > 0 && m == rst_at) begin
        reset = 1'b1;
        face_coords_ready = 1'b0;
        #1;
        check("mid_reset_tx", uart_tx, 1'b1);
        check("mid_reset_busy", tx_busy, 1'b0);
        check("mid_reset_done", tx_done, 1'b0);
      end
      if (rst_at > 0 && m == rst_at + 3) reset = 1'b0;
    end
  endtask

  task automatic decode(input int n);
    int         p;
    logic [7:0] b;
    n_dec    = 0;
    stop_bad = 0;
    done_cnt = 0;
    done_pos = -1;
    for (int i = 1; i <= n; i++) begin
      if (done_log[i]) begin
        done_cnt++;
        done_pos = i;
      end
    end
    p = 1;
    while (p + 10 * CPB - 1 <= n) begin
      if (tx_log[p-1] && !tx_log[p] && n_dec < 16) begin
        for (int i = 0; i < 8; i++) b[i] = tx_log[p + CPB * (i + 1) + 1];
        if (tx_log[p + 1] !== 1'b0) stop_bad++;
        if (tx_log[p + 9 * CPB + 1] !== 1'b1) stop_bad++;
        dec_byte[n_dec] = b;
        dec_pos[n_dec]  = p;
        n_dec++;
        p += 10 * CPB;
      end else begin
        p++;
      end
    end
  endtask

  task automatic check_line(input string name, input int lo, input int hi,
                            input logic tx_exp, input logic busy_exp);
    int bad = 0;
    for (int i = lo; i <= hi; i++) begin
      if (tx_log[i] !== tx_exp || busy_log[i] !== busy_exp || done_log[i] !== 1'b0) bad++;
    end
    check(name, bad, 0);
  endtask

  task automatic check_xfer(input string tag, input logic [63:0] exp, input int first);
    check({tag, "_nbytes"}, n_dec, 8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s_byte%0d", tag, k), dec_byte[k], exp[63 - 8 * k -: 8]);
    end
    check({tag, "_framing"}, stop_bad, 0);
    check({tag, "_first_fall"}, dec_pos[0], first);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_done_pos"}, done_pos, dec_pos[7] + 10 * CPB);
    if (done_cnt == 1) begin
      check({tag, "_busy_at_done"}, busy_log[done_pos], 1'b0);
      check({tag, "_busy_before_done"}, busy_log[done_pos - 1], 1'b1);
    end
  endtask

  initial begin
    vecs[0] = '{w0: 32'h0000_0123, w1: 32'hDEAD_BEEF, exp: 64'h23_01_00_00_EF_BE_AD_DE};
    vecs[1] = '{w0: 32'h8040_2010, w1: 32'hFF00_A55A, exp: 64'h10_20_40_80_5A_A5_00_FF};
    vecs[2] = '{w0: 32'h1234_5678, w1: 32'h0F1E_2D3C, exp: 64'h78_56_34_12_3C_2D_1E_0F};
    clear_ctl();

    repeat (3) @(negedge clock);
    check("reset_tx", uart_tx, 1'b1);
    check("reset_busy", tx_busy, 1'b0);
    check("reset_done", tx_done, 1'b0);
    reset = 1'b0;
    @(negedge clock);

    // Plain transfers with CTS high: 41-cycle frame pitch, done at T+329.
    for (int v = 0; v < 3; v++) begin
      clear_ctl();
      launch({vecs[v].w1, vecs[v].w0});
      capture(340);
      decode(340);
      check_xfer($sformatf("vec%0d", v), vecs[v].exp, 2);
      check($sformatf("vec%0d_tx_wait", v), tx_log[1], 1'b1);
      check($sformatf("vec%0d_busy_t1", v), busy_log[1], 1'b1);
      check($sformatf("vec%0d_pitch", v), dec_pos[7] - dec_pos[0], 7 * 41);
      check($sformatf("vec%0d_done_cyc", v), done_pos, 329);
    end

    // CTS low at start, raised at T+100: line idle and busy until then.
    clear_ctl();
    uart_cts  = 1'b0;
    cts_on_at = 100;
    launch({vecs[0].w1, vecs[0].w0});
    capture(440);
    decode(440);
    check_line("cts_hold", 1, 100, 1'b1, 1'b1);
    check_xfer("cts_late", vecs[0].exp, 101);
    check("cts_late_done_cyc", done_pos, 428);

    // CTS dropped during byte 2 data bits: byte 2 completes, byte 3 waits.
    clear_ctl();
    cts_off_at = 95;
    cts_on_at  = 200;
    launch({vecs[1].w1, vecs[1].w0});
    capture(420);
    decode(420);
    check_xfer("cts_drop", vecs[1].exp, 2);
    check("cts_drop_byte2_pos", dec_pos[2], 84);
    check_line("cts_drop_idle", 124, 200, 1'b1, 1'b1);
    check("cts_drop_byte3_pos", dec_pos[3], 201);

    // Second ready edge during byte 4 and coordinate change mid-transfer are ignored.
    clear_ctl();
    pulse_at   = 180;
    coords_at  = 100;
    coords_new = {vecs[1].w1, vecs[1].w0};
    launch({vecs[2].w1, vecs[2].w0});
    capture(340);
    decode(340);
    check_xfer("reedge", vecs[2].exp, 2);
    check_line("reedge_after", 330, 340, 1'b1, 1'b0);
    launch({vecs[1].w1, vecs[1].w0});
    capture(340);
    decode(340);
    check_xfer("fresh", vecs[1].exp, 2);

    // Reset during byte 5 data bits, then a full transfer from byte 0.
    clear_ctl();
    rst_at = 220;
    launch({vecs[0].w1, vecs[0].w0});
    capture(340);
    decode(340);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rst_byte%0d", k), dec_byte[k], vecs[0].exp[63 - 8 * k -: 8]);
    end
    check("rst_no_done", done_cnt, 0);
    check_line("rst_idle", 221, 340, 1'b1, 1'b0);
    clear_ctl();
    launch({vecs[1].w1, vecs[1].w0});
    capture(340);
    decode(340);
    check_xfer("post_rst", vecs[1].exp, 2);

    // Ready held high: exactly one transfer, then stays idle.
    clear_ctl();
    launch({vecs[2].w1, vecs[2].w0});
    capture(340);
    decode(340);
    check_xfer("held", vecs[2].exp, 2);
    capture(120);
    check_line("held_idle", 1, 120, 1'b1, 1'b0);
    face_coords_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
